// File: rtl/snake_pkg.sv
// Shared definitions for the snake game datapath.
// Holds the game state encoding, default divider taps and level widths
// that the tick scheduler, display and score blocks all agree on.
// No ports: package only.
package snake_pkg;

  // Game run state; the numeric values are visible on the state output.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } game_state_t;

  // Default clkdiv tap for the slowest speed level.
  localparam int TAP_BASE_DEF       = 24;
  // Default clkdiv tap driving the display scan.
  localparam int SCAN_TAP_DEF       = 17;
  localparam int NUM_LEVELS_DEF     = 8;
  localparam int FOOD_PER_LEVEL_DEF = 4;

  // Width of a counter holding 0..n-1; never narrower than one bit.
  function automatic int level_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int LEVEL_W = level_width(NUM_LEVELS_DEF);

endpackage

// File: rtl/edge_pulse.sv
// Registered rising-edge detector.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   din          : level signal to watch
//   en           : qualifies the output pulse
//   preload      : load history with preload_din instead of din this cycle
//   preload_din  : history value used when preload is high
//   pulse        : one-cycle pulse, one clock after din is first seen high
module edge_pulse (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic en,
  input  logic preload,
  input  logic preload_din,
  output logic pulse
);

  logic din_q;

  // The history register normally tracks din. When the watched signal is
  // about to be swapped for a different source, preload lets the caller
  // seed the history with the new source so the swap itself never looks
  // like a rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      din_q <= 1'b0;
      pulse <= 1'b0;
    end else begin
      pulse <= din & ~din_q & en;
      din_q <= preload ? preload_din : din;
    end
  end

endmodule

// File: rtl/game_tick_ctrl.sv
// Game tick scheduler: owns the run state and the speed level, and turns
// the free-running clkdiv bus into single-cycle move and scan enables.
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   clkdiv      : free-running counter from clk_div
//   start       : pulse, leaves IDLE/OVER and starts a fresh game
//   pause       : pulse, toggles RUN <-> PAUSE
//   food_eaten  : pulse, counts toward the next speed level while running
//   game_over   : pulse, ends the game while running
//   step_en     : one-cycle snake move enable
//   scan_en     : one-cycle display scan enable (runs in every state)
//   level       : current speed level
//   state       : IDLE=0, RUN=1, PAUSE=2, OVER=3
//   running     : high while in RUN
module game_tick_ctrl
  import snake_pkg::*;
#(
  parameter  int TAP_BASE       = TAP_BASE_DEF,
  parameter  int NUM_LEVELS     = NUM_LEVELS_DEF,
  parameter  int FOOD_PER_LEVEL = FOOD_PER_LEVEL_DEF,
  parameter  int SCAN_TAP       = SCAN_TAP_DEF,
  localparam int LW             = level_width(NUM_LEVELS),
  localparam int FW             = level_width(FOOD_PER_LEVEL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   clkdiv,
  input  logic          start,
  input  logic          pause,
  input  logic          food_eaten,
  input  logic          game_over,
  output logic          step_en,
  output logic          scan_en,
  output logic [LW-1:0] level,
  output logic [1:0]    state,
  output logic          running
);

  game_state_t   state_q, state_d;
  logic [LW-1:0] level_q, level_d;
  logic [FW-1:0] food_q, food_d;
  logic          food_hit;
  logic [4:0]    tap_idx, tap_idx_next;
  logic          tap, tap_next, step_ok;

  // Next-state logic for the game FSM and the level/food counters.
  // A game_over in the same cycle as food_eaten wins: the food is dropped.
  // The food counter keeps wrapping once the level has saturated.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    food_d   = food_q;
    food_hit = (state_q == ST_RUN) && !game_over && food_eaten;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d = ST_RUN;
          level_d = '0;
          food_d  = '0;
        end
      end
      ST_RUN: begin
        if (game_over)  state_d = ST_OVER;
        else if (pause) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (pause) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
    if (food_hit) begin
      if (food_q == FW'(FOOD_PER_LEVEL - 1)) begin
        food_d = '0;
        if (level_q != LW'(NUM_LEVELS - 1)) level_d = level_q + 1'b1;
      end else begin
        food_d = food_q + 1'b1;
      end
    end
  end

  // Registered FSM state, counters and the running flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      level_q <= '0;
      food_q  <= '0;
      running <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      food_q  <= food_d;
      running <= (state_d == ST_RUN);
    end
  end

  // Faster levels pick lower clkdiv bits. tap_next is the bit that will be
  // selected once a level change lands; it seeds the step history so that
  // switching taps cannot fake a rising edge.
  always_comb begin
    tap_idx      = 5'(TAP_BASE) - 5'(level_q);
    tap_idx_next = 5'(TAP_BASE) - 5'(level_d);
    tap          = clkdiv[tap_idx];
    tap_next     = clkdiv[tap_idx_next];
    step_ok      = (state_q == ST_RUN) && !game_over;
  end

  edge_pulse u_step (
    .clk         (clk),
    .rst         (rst),
    .din         (tap),
    .en          (step_ok),
    .preload     (level_d != level_q),
    .preload_din (tap_next),
    .pulse       (step_en)
  );

  edge_pulse u_scan (
    .clk         (clk),
    .rst         (rst),
    .din         (clkdiv[SCAN_TAP]),
    .en          (1'b1),
    .preload     (1'b0),
    .preload_din (1'b0),
    .pulse       (scan_en)
  );

  assign level = level_q;
  assign state = state_q;

endmodule
